// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived totals and the shared coordinate type.
// Also holds the colour-depth expansion helpers used by the pixel driver.
package vga_timing_pkg;

  typedef logic [10:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // Bit replication keeps full-scale inputs at full scale (7 -> FF, 3 -> FF).
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {4{c}};
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with an asynchronous reset to a programmable fill value.
module delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_driver.sv
// Raster counters plus registered VGA DAC outputs; sync/blank are delayed to line up
// with the RGB value that the object pipeline returns PIPE_DELAY cycles later.
module vga_pixel_driver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] RGBIn,
  output coord_t     pixelX,
  output coord_t     pixelY,
  output logic       startOfFrame,
  output logic       endOfLine,
  output logic [7:0] vgaR,
  output logic [7:0] vgaG,
  output logic [7:0] vgaB,
  output logic       hsyncN,
  output logic       vsyncN,
  output logic       blankN
);

  localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t     r_h_cnt;
  coord_t     r_v_cnt;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_active;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic [2:0] w_dly;
  logic       r_hsync_n;
  logic       r_vsync_n;
  logic       r_blank_n;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + coord_t'(1);
    end else begin
      r_h_cnt <= r_h_cnt + coord_t'(1);
    end
  end

  assign pixelX       = r_h_cnt;
  assign pixelY       = r_v_cnt;
  assign startOfFrame = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign endOfLine    = w_h_last;

  assign w_active  = (r_h_cnt < coord_t'(H_ACTIVE)) && (r_v_cnt < coord_t'(V_ACTIVE));
  assign w_hsync_n = !((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END));
  assign w_vsync_n = !((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END));

  // Delay-line fill value is the idle state: syncs deasserted, not active.
  delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(3'b110)
  ) u_align (
    .clk   (clk),
    .resetN(resetN),
    .i_d   ({w_hsync_n, w_vsync_n, w_active}),
    .o_q   (w_dly)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else begin
      r_hsync_n <= w_dly[2];
      r_vsync_n <= w_dly[1];
      r_blank_n <= w_dly[0];
      if (w_dly[0]) begin
        r_red   <= expand3(RGBIn[7:5]);
        r_green <= expand3(RGBIn[4:2]);
        r_blue  <= expand2(RGBIn[1:0]);
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign hsyncN = r_hsync_n;
  assign vsyncN = r_vsync_n;
  assign blankN = r_blank_n;
  assign vgaR   = r_red;
  assign vgaG   = r_green;
  assign vgaB   = r_blue;

endmodule
